// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared types and constants for the divider request controller.
//               Holds the controller state encoding, the RUN timeout limit,
//               and the packed result record that is presented to the
//               consumer.
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

   // Operand width that the result record is sized for. The controller's N
   // must match this value.
   localparam int unsigned DIV_N = 4;

   // RUN cycles allowed before a division is declared hung.
   function automatic int unsigned f_timeout_lim(input int unsigned n);
      return 2 * n + 4;
   endfunction

   localparam int unsigned DIV_TIMEOUT_LIM = f_timeout_lim(DIV_N);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2,
      ST_HOLD = 2'd3
   } div_state_t;

   typedef struct packed {
      logic [DIV_N-1:0] quotient;
      logic [DIV_N-1:0] remainder;
      logic             div_by_zero;
      logic             timeout;
   } div_result_t;

endpackage : div_pkg
`default_nettype wire

// File: rtl/sync_fifo2.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo2
// Description : Two-entry synchronous FIFO with wrapping pointers.
//               Pushes are ignored when full, pops are ignored when empty.
// Ports       : clk, rst (async, active-low)
//               i_push/i_data  - write side
//               i_pop/o_data   - read side, o_data shows the head entry
//               o_empty/o_full - registered occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_data,
   input  logic         i_pop,
   output logic [W-1:0] o_data,
   output logic         o_empty,
   output logic         o_full
);

   logic [W-1:0] r_mem [2];
   logic         r_wptr;
   logic         r_rptr;
   logic [1:0]   r_count;

   logic w_push;
   logic w_pop;

   assign o_full  = (r_count == 2'd2);
   assign o_empty = (r_count == 2'd0);
   assign w_push  = i_push & ~o_full;
   assign w_pop   = i_pop & ~o_empty;
   assign o_data  = r_mem[r_rptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule : sync_fifo2
`default_nettype wire

// File: rtl/div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : div_issue_ctrl
// Description : Request-side controller for an external divider core.
//               Operand pairs are queued in a 2-entry FIFO and issued one at
//               a time. The core has no load strobe, so each division is
//               started by a one-cycle low pulse on div_rst_n. Results,
//               divide-by-zero and timeout flags are held on a valid/ready
//               output stream.
// Ports       : clk, rst (async, active-low)
//               in_*   - operand stream (valid/ready)
//               out_*  - result stream (valid/ready)
//               div_*  - connection to the divider core
// Revision    : 1.0 - initial release
// ============================================================================
module div_issue_ctrl
   import div_pkg::*;
#(
   parameter int unsigned N = DIV_N
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [N-1:0]   in_dividend,
   input  logic [N-1:0]   in_divisor,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [N-1:0]   out_quotient,
   output logic [N-1:0]   out_remainder,
   output logic           out_div_by_zero,
   output logic           out_timeout,
   output logic           div_rst_n,
   output logic [N-1:0]   div_dividend,
   output logic [N-1:0]   div_divisor,
   input  logic [N-1:0]   div_quotient,
   input  logic [2*N-1:0] div_remainder,
   input  logic           div_done,
   input  logic           div_error
);

   localparam int unsigned LIM = f_timeout_lim(N);
   localparam int unsigned CW  = $clog2(LIM + 1);

   div_state_t  r_state;
   div_result_t r_res;
   logic        r_out_valid;
   logic        r_div_rst_n;
   logic [N-1:0] r_dividend;
   logic [N-1:0] r_divisor;
   logic [CW-1:0] r_cnt;

   logic [2*N-1:0] w_head;
   logic [N-1:0]   w_head_dividend;
   logic [N-1:0]   w_head_divisor;
   logic           w_empty;
   logic           w_full;
   logic           w_pop;
   logic [CW-1:0]  w_cnt_next;
   logic           w_unused_rem_hi;

   // Only the low half of the core's remainder is meaningful for N-bit operands.
   assign w_unused_rem_hi = ^div_remainder[2*N-1:N];

   assign w_head_dividend = w_head[2*N-1:N];
   assign w_head_divisor  = w_head[N-1:0];
   assign w_cnt_next      = r_cnt + CW'(1);

   // The head leaves the FIFO exactly when it is latched into the core
   // operand registers: from IDLE, or from HOLD on the output handshake.
   assign w_pop = ~w_empty &
                  ((r_state == ST_IDLE) | ((r_state == ST_HOLD) & out_ready));

   sync_fifo2 #(
      .W (2 * N)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (in_valid),
      .i_data  ({in_dividend, in_divisor}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   assign in_ready        = ~w_full;
   assign out_valid       = r_out_valid;
   assign out_quotient    = r_res.quotient;
   assign out_remainder   = r_res.remainder;
   assign out_div_by_zero = r_res.div_by_zero;
   assign out_timeout     = r_res.timeout;
   assign div_rst_n       = r_div_rst_n;
   assign div_dividend    = r_dividend;
   assign div_divisor     = r_divisor;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_res       <= '0;
         r_out_valid <= 1'b0;
         r_div_rst_n <= 1'b1;
         r_dividend  <= '0;
         r_divisor   <= '0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_dividend  <= w_head_dividend;
                  r_divisor   <= w_head_divisor;
                  r_div_rst_n <= 1'b0;
                  r_state     <= ST_LOAD;
               end
            end

            ST_LOAD: begin
               r_div_rst_n <= 1'b1;
               r_cnt       <= '0;
               r_state     <= ST_RUN;
            end

            ST_RUN: begin
               r_cnt <= w_cnt_next;
               if (div_done) begin
                  // Core quotient/remainder are meaningless on divide by zero.
                  r_res.quotient    <= div_error ? '0 : div_quotient;
                  r_res.remainder   <= div_error ? '0 : div_remainder[N-1:0];
                  r_res.div_by_zero <= div_error;
                  r_res.timeout     <= 1'b0;
                  r_out_valid       <= 1'b1;
                  r_state           <= ST_HOLD;
               end else if (w_cnt_next == CW'(LIM)) begin
                  r_res.quotient    <= '0;
                  r_res.remainder   <= '0;
                  r_res.div_by_zero <= 1'b0;
                  r_res.timeout     <= 1'b1;
                  r_out_valid       <= 1'b1;
                  r_state           <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (out_ready) begin
                  r_out_valid       <= 1'b0;
                  r_res.div_by_zero <= 1'b0;
                  r_res.timeout     <= 1'b0;
                  if (!w_empty) begin
                     r_dividend  <= w_head_dividend;
                     r_divisor   <= w_head_divisor;
                     r_div_rst_n <= 1'b0;
                     r_state     <= ST_LOAD;
                  end else begin
                     r_state <= ST_IDLE;
                  end
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule : div_issue_ctrl
`default_nettype wire

// File: tb/tb_div_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_issue_ctrl
// Description : Self-checking bench for div_issue_ctrl. Contains a behavioural
//               stand-in for the divider core (reset-started, N+1 cycle run,
//               optional stuck-done) and a queue-based reference model that
//               computes expected results with plain integer division.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_issue_ctrl;
   import div_pkg::*;

   localparam int N   = 4;
   localparam int LIM = 2 * N + 4;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           in_valid;
   logic           in_ready;
   logic [N-1:0]   in_dividend;
   logic [N-1:0]   in_divisor;
   logic           out_valid;
   logic           out_ready;
   logic [N-1:0]   out_quotient;
   logic [N-1:0]   out_remainder;
   logic           out_div_by_zero;
   logic           out_timeout;
   logic           div_rst_n;
   logic [N-1:0]   div_dividend;
   logic [N-1:0]   div_divisor;
   logic [N-1:0]   div_quotient;
   logic [2*N-1:0] div_remainder;
   logic           div_done;
   logic           div_error;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   int acc_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   div_issue_ctrl #(.N(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_dividend     (in_dividend),
      .in_divisor      (in_divisor),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_quotient    (out_quotient),
      .out_remainder   (out_remainder),
      .out_div_by_zero (out_div_by_zero),
      .out_timeout     (out_timeout),
      .div_rst_n       (div_rst_n),
      .div_dividend    (div_dividend),
      .div_divisor     (div_divisor),
      .div_quotient    (div_quotient),
      .div_remainder   (div_remainder),
      .div_done        (div_done),
      .div_error       (div_error)
   );

   // ---------------- divider core stand-in ----------------
   // Reset released at E2 -> counts on E3.., done rises on E(N+3);
   // divide by zero raises done on E3 with garbage quotient.
   logic         core_rst_n;
   int           c_cnt;
   logic         c_done;
   logic [N-1:0] c_q;
   logic [2*N-1:0] c_r;
   logic         stuck = 1'b0;

   assign core_rst_n    = div_rst_n & rst;
   assign div_done      = c_done & ~stuck;
   assign div_quotient  = c_q;
   assign div_remainder = c_r;
   assign div_error     = (div_divisor == '0);

   always @(posedge clk or negedge core_rst_n) begin
      if (!core_rst_n) begin
         c_cnt  <= 0;
         c_done <= 1'b0;
         c_q    <= '0;
         c_r    <= '0;
      end else if (!c_done) begin
         if (div_divisor == '0) begin
            c_done <= 1'b1;
            c_q    <= '1;
            c_r    <= '1;
         end else if (c_cnt == N) begin
            c_done <= 1'b1;
            c_q    <= div_dividend / div_divisor;
            c_r    <= {4'hA, div_dividend % div_divisor};
         end else begin
            c_cnt <= c_cnt + 1;
         end
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      int q;
      int r;
      bit dbz;
      bit to;
   } exp_t;

   exp_t exp_q[$];

   function automatic exp_t ref_div(input int a, input int b, input bit hung);
      exp_t e;
      e.q = 0; e.r = 0; e.dbz = 1'b0; e.to = 1'b0;
      if (hung)        e.to  = 1'b1;
      else if (b == 0) e.dbz = 1'b1;
      else begin
         e.q = a / b;
         e.r = a % b;
      end
      return e;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- start-pulse / operand-hold monitor ----------------
   int             low_run = 0;
   bit             win     = 1'b0;
   logic [2*N-1:0] snap;

   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         low_run = 0;
         win     = 1'b0;
      end else if (div_rst_n === 1'b0) begin
         low_run++;
         snap = {div_dividend, div_divisor};
         win  = 1'b1;
      end else begin
         if (low_run != 0) begin
            check("rst_pulse_len", low_run, 1);
            low_run = 0;
         end
         if (win) begin
            check("operand_hold", {div_dividend, div_divisor}, snap);
            if (out_valid && out_ready) win = 1'b0;
         end
      end
   end

   // ---------------- stimulus helpers (called at a negedge) ----------------
   task automatic push(input int a, input int b, input bit hung);
      bit ok = 1'b0;
      in_valid    = 1'b1;
      in_dividend = N'(a);
      in_divisor  = N'(b);
      for (int k = 0; k < 60 && !ok; k++) begin
         if (in_ready === 1'b1) begin
            @(posedge clk);
            @(negedge clk);
            acc_cyc = cyc;
            exp_q.push_back(ref_div(a, b, hung));
            ok = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!ok) check("push_accept", 0, 1);
   endtask

   task automatic wait_valid(output int when);
      bit seen = 1'b0;
      when = -1;
      for (int k = 0; k < 200 && !seen; k++) begin
         if (out_valid === 1'b1) begin
            when = cyc;
            seen = 1'b1;
         end else begin
            @(negedge clk);
         end
      end
      if (!seen) check("out_valid_wait", 0, 1);
   endtask

   task automatic consume(input string tag, input int stall, output int hs_cyc);
      exp_t e;
      int   t;
      hs_cyc = -1;
      out_ready = 1'b0;
      wait_valid(t);
      if (t < 0) return;
      if (exp_q.size() == 0) begin
         check({tag, "_unexpected"}, 1, 0);
         return;
      end
      e = exp_q.pop_front();
      for (int s = 0; s <= stall; s++) begin
         check({tag, "_valid"}, out_valid, 1);
         check({tag, "_q"},     out_quotient, e.q);
         check({tag, "_r"},     out_remainder, e.r);
         check({tag, "_dbz"},   out_div_by_zero, e.dbz);
         check({tag, "_to"},    out_timeout, e.to);
         if (s < stall) @(negedge clk);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      hs_cyc    = cyc;
      out_ready = 1'b0;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int t, hs, cnt, a, b;
      in_valid    = 1'b0;
      in_dividend = '0;
      in_divisor  = '0;
      out_ready   = 1'b0;

      // Reset values
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      check("rst_in_ready",  in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_q",         out_quotient, 0);
      check("rst_r",         out_remainder, 0);
      check("rst_dbz",       out_div_by_zero, 0);
      check("rst_to",        out_timeout, 0);
      check("rst_div_rst_n", div_rst_n, 1);
      check("rst_div_a",     div_dividend, 0);
      check("rst_div_b",     div_divisor, 0);

      // 13/3: latency N+4
      push(13, 3, 1'b0);
      in_valid = 1'b0;
      wait_valid(t);
      check("lat_13_3", t - acc_cyc, N + 4);
      consume("r13_3", 1, hs);

      // 7/0: latency 4, divide by zero
      @(negedge clk);
      push(7, 0, 1'b0);
      in_valid = 1'b0;
      wait_valid(t);
      check("lat_7_0", t - acc_cyc, 4);
      consume("r7_0", 0, hs);

      // Three back-to-back pushes while stalled; FIFO fills
      @(negedge clk);
      push(15, 2, 1'b0);
      push(9, 4, 1'b0);
      push(6, 5, 1'b0);
      in_valid = 1'b0;
      check("full_in_ready", in_ready, 0);
      consume("stall1", 5, hs);
      wait_valid(t);
      check("b2b_lat1", t - hs, N + 3);
      consume("stall2", 3, hs);
      wait_valid(t);
      check("b2b_lat2", t - hs, N + 3);
      consume("stall3", 2, hs);

      // Hung core: timeout after LIM RUN cycles, then normal operation
      @(negedge clk);
      stuck = 1'b1;
      push(5, 1, 1'b1);
      in_valid = 1'b0;
      wait_valid(t);
      check("lat_timeout", t - acc_cyc, LIM + 2);
      consume("tmo", 2, hs);
      stuck = 1'b0;
      @(negedge clk);
      push(9, 3, 1'b0);
      in_valid = 1'b0;
      consume("after_tmo", 1, hs);

      // Reset during RUN with one entry queued
      @(negedge clk);
      push(10, 3, 1'b0);
      push(11, 2, 1'b0);
      in_valid = 1'b0;
      repeat (3) @(negedge clk);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_in_ready",  in_ready, 1);
      check("mid_rst_div_rst_n", div_rst_n, 1);
      check("mid_rst_div_a",     div_dividend, 0);
      check("mid_rst_div_b",     div_divisor, 0);
      check("mid_rst_q",         out_quotient, 0);
      exp_q.delete();
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (20) @(negedge clk);
      check("post_rst_idle_valid", out_valid, 0);
      check("post_rst_in_ready",   in_ready, 1);
      push(8, 2, 1'b0);
      in_valid = 1'b0;
      wait_valid(t);
      check("lat_8_2", t - acc_cyc, N + 4);
      consume("r8_2", 1, hs);

      // Randomized traffic against the reference queue
      for (int it = 0; it < 15; it++) begin
         @(negedge clk);
         cnt = int'($urandom_range(1, 2));
         for (int j = 0; j < cnt; j++) begin
            a = int'($urandom_range(0, 15));
            b = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 15));
            push(a, b, 1'b0);
         end
         in_valid = 1'b0;
         for (int j = 0; j < cnt; j++) begin
            consume("rnd", int'($urandom_range(0, 3)), hs);
         end
      end

      repeat (5) @(negedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, observed running expected done");
      $fatal(1, "watchdog expired");
   end

endmodule : tb_div_issue_ctrl
`default_nettype wire

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

Request-side controller for the `divider` core. It accepts operand pairs on a valid/ready stream into a 2-entry FIFO and sequences one division at a time through the core. The core has no load strobe, so each division is started by pulsing the core's asynchronous active-low reset. Results, plus divide-by-zero and timeout flags, are returned on a valid/ready output stream.

## Interface
- N, default 4: operand width; must match the attached `divider` instance.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  FIFO not full; handshake when in_valid & in_ready at posedge.
- in_dividend  in  N  dividend.
- in_divisor  in  N  divisor.
- out_valid  out  1  result held.
- out_ready  in  1  consumer accepts the result at posedge when out_valid & out_ready.
- out_quotient  out  N  quotient.
- out_remainder  out  N  remainder; low N bits of the core's 2N-bit remainder.
- out_div_by_zero  out  1  divisor was 0; quotient and remainder are forced to 0.
- out_timeout  out  1  core failed to finish; quotient and remainder are forced to 0.
- div_rst_n  out  1  registered start pulse to the core's rst; never combinational.
- div_dividend  out  N  registered operand to the core.
- div_divisor  out  N  registered operand to the core.
- div_quotient  in  N  from the core.
- div_remainder  in  2N  from the core.
- div_done  in  1  from the core.
- div_error  in  1  from the core.

## Operation
- Reset values:
  - in_ready=1, out_valid=0, all result outputs and flags 0.
  - div_rst_n=1; div_dividend=0, div_divisor=0.
  - FIFO empty; state IDLE; timeout counter 0.
- FIFO: 2 entries, pointers wrap; push on input handshake, pop on the IDLE->LOAD transition.
  - in_ready = !full, registered view.
  - A simultaneous push and pop when full is not allowed: in_ready is already 0.
- FSM states and transitions:
  - IDLE: if the FIFO is non-empty, latch the head into div_dividend/div_divisor, pop, set div_rst_n<=0, go to LOAD.
  - LOAD: exactly one cycle with div_rst_n=0; set div_rst_n<=1, clear the timeout counter, go to RUN.
  - RUN: increment the timeout counter each cycle.
    - If div_done is seen: capture div_quotient and div_remainder[N-1:0], set out_div_by_zero=div_error, out_valid<=1, go to HOLD.
    - Else if the counter reaches 2N+4: capture zeros, set out_timeout=1, out_valid<=1, go to HOLD.
  - HOLD: outputs stay stable until the output handshake. On handshake, out_valid<=0 and the flags clear.
    - If the FIFO is non-empty, go directly to LOAD and pop/latch as in IDLE.
    - Else go to IDLE.
- div_dividend and div_divisor are held constant from LOAD through HOLD, because the core's error output is combinational on its divisor.
- Input pushes continue in every state while the FIFO is not full.

## Timing
- Accept at edge E0 with IDLE and an empty FIFO:
  - Edge E1: LOAD entered; div_rst_n low from E1 to E2, so the core samples reset at E2.
  - The core runs on edges E3..E(N+3).
  - div_done is high after E(N+3) and sampled at E(N+4); out_valid is high after E(N+4).
  - Latency is N+4 cycles (8 for N=4).
- Divide by zero: the core's done rises after E3, so out_valid rises after E4 (latency 4).
- HOLD->LOAD back-to-back: the next result follows N+3 cycles after the output handshake edge.
- rst asserted mid-operation: all state returns to reset values immediately and queued requests are discarded. div_rst_n goes to 1, and the core has its own reset tied to the same system reset.
- out_* change only on a capture edge or on the handshake edge.

## Structure
- Shared package `div_pkg`:
  - state enum (IDLE, LOAD, RUN, HOLD);
  - localparam for the timeout limit 2N+4;
  - the result struct {quotient, remainder, div_by_zero, timeout}.
- One natural sub-module: `sync_fifo2` (parameterised width, depth 2, asynchronous active-low reset), holding {dividend, divisor}.
- The top level instantiates `sync_fifo2` only. `divider` is attached externally in the test bench and the system.

## Test plan
- N=4, push 13/3 with out_ready=1 -> out_valid 8 cycles after accept, quotient=4, remainder=1, both flags 0.
- Push 7/0 -> out_valid after 4 cycles, quotient=0, remainder=0, out_div_by_zero=1.
- out_ready=0, push 15/2, 9/4 and 6/5 back-to-back -> in_ready drops after the second FIFO entry.
  - Results 7r1, 2r1, 1r1 are delivered in order as out_ready is toggled.
  - Values stay stable while stalled.
- Replace the core with a model whose div_done is stuck at 0 -> out_timeout=1 after 2N+4=12 RUN cycles, quotient=0, remainder=0, then normal operation resumes.
- Assert rst during RUN with one entry queued -> outputs return to reset values, the FIFO is empty, and the next push 8/2 returns 4r0.
- Check div_rst_n is low for exactly one cycle per division, and div_dividend/div_divisor are constant from LOAD through HOLD.
